// File: rtl/mem_ring_pkg.sv
// Shared types and default widths for the IMemory-backed ring buffer.
package mem_ring_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    WR_WAIT,
    RD_WAIT,
    RD_DRAIN
  } state_e;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } grant_e;
endpackage

// File: rtl/mem_ring_if.sv
// IMemory bus between the ring buffer (master) and the packet memory responder (slave).
interface mem_ring_if #(
  parameter int DATA_W = mem_ring_pkg::DATA_W,
  parameter int ADDR_W = mem_ring_pkg::ADDR_W
);
  logic [DATA_W-1:0] mem_wr_data;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic              mem_wr_enable;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic              mem_rd_enable;
  logic [DATA_W-1:0] mem_rd_data;
  logic              mem_rd_ready;
  logic              mem_busy;

  modport master (
    output mem_wr_data, mem_wr_addr, mem_wr_enable, mem_rd_addr, mem_rd_enable,
    input  mem_rd_data, mem_rd_ready, mem_busy
  );

  modport slave (
    input  mem_wr_data, mem_wr_addr, mem_wr_enable, mem_rd_addr, mem_rd_enable,
    output mem_rd_data, mem_rd_ready, mem_busy
  );
endinterface

// File: rtl/mem_ring_arbiter.sv
// Round-robin choice between a pending write and a pending read; remembers the last grant.
module mem_ring_arbiter
  import mem_ring_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   wr_cand,
  input  logic   rd_cand,
  input  logic   advance,
  output logic   grant_valid,
  output grant_e grant
);
  grant_e last_grant_q, last_grant_d;

  always_comb begin
    grant_valid  = wr_cand || rd_cand;
    grant        = READ;
    last_grant_d = last_grant_q;
    if (wr_cand && rd_cand) begin
      if (last_grant_q == READ) grant = WRITE;
      else                      grant = READ;
    end else if (wr_cand) begin
      grant = WRITE;
    end
    if (advance && grant_valid) last_grant_d = grant;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_grant_q <= READ;
    else     last_grant_q <= last_grant_d;
  end
endmodule

// File: rtl/mem_ring_buffer.sv
// Circular word FIFO layered on the IMemory packet memory; one memory operation at a time.
module mem_ring_buffer #(
  parameter int                DATA_W    = mem_ring_pkg::DATA_W,
  parameter int                ADDR_W    = mem_ring_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_valid,
  input  logic [DATA_W-1:0] push_data,
  output logic              push_ready,
  input  logic              pop_req,
  output logic              pop_valid,
  output logic [DATA_W-1:0] pop_data,
  output logic              underflow,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  mem_ring_if.master        mem
);
  import mem_ring_pkg::*;

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              pop_pending_q, pop_pending_d;
  logic              underflow_q, underflow_d;
  logic              pop_valid_q, pop_valid_d;
  logic [DATA_W-1:0] pop_data_q, pop_data_d;

  grant_e grant;
  logic   grant_valid, wr_cand, rd_cand, idle_ok, wr_issue, rd_issue;

  assign full     = (count_q == DEPTH);
  assign empty    = (count_q == '0);
  assign wr_cand  = push_valid && !full;
  assign rd_cand  = pop_pending_q && !empty;
  // rst gates issue so the combinational strobes stay low while reset is held
  assign idle_ok  = (state_q == IDLE) && !mem.mem_busy && !rst;
  assign wr_issue = idle_ok && grant_valid && (grant == WRITE);
  assign rd_issue = idle_ok && grant_valid && (grant == READ);

  mem_ring_arbiter u_arb (
    .clk         (clk),
    .rst         (rst),
    .wr_cand     (wr_cand),
    .rd_cand     (rd_cand),
    .advance     (wr_issue || rd_issue),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  assign push_ready        = wr_issue;
  assign mem.mem_wr_enable = wr_issue;
  assign mem.mem_wr_addr   = BASE_ADDR + wr_ptr_q;
  assign mem.mem_wr_data   = push_data;
  assign mem.mem_rd_enable = rd_issue;
  assign mem.mem_rd_addr   = BASE_ADDR + rd_ptr_q;
  assign pop_valid         = pop_valid_q;
  assign pop_data          = pop_data_q;
  assign underflow         = underflow_q;
  assign count             = count_q;

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    pop_pending_d = pop_pending_q;
    pop_valid_d   = 1'b0;
    pop_data_d    = pop_data_q;
    // a write issued this cycle counts as in flight, so the pop waits for it
    underflow_d   = pop_req && !pop_pending_q && empty && !wr_issue;

    if (rd_issue)
      pop_pending_d = 1'b0;
    else if (pop_req && !pop_pending_q && !underflow_d)
      pop_pending_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (wr_issue) begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          count_d  = count_q + 1'b1;
          state_d  = WR_WAIT;
        end else if (rd_issue) begin
          state_d = RD_WAIT;
        end
      end
      WR_WAIT:  if (!mem.mem_busy) state_d = IDLE;
      RD_WAIT: begin
        if (mem.mem_rd_ready) begin
          pop_data_d  = mem.mem_rd_data;
          pop_valid_d = 1'b1;
          rd_ptr_d    = rd_ptr_q + 1'b1;
          count_d     = count_q - 1'b1;
          state_d     = RD_DRAIN;
        end
      end
      RD_DRAIN: if (!mem.mem_busy) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      pop_pending_q <= 1'b0;
      underflow_q   <= 1'b0;
      pop_valid_q   <= 1'b0;
      pop_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      pop_pending_q <= pop_pending_d;
      underflow_q   <= underflow_d;
      pop_valid_q   <= pop_valid_d;
      pop_data_q    <= pop_data_d;
    end
  end
endmodule
